imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//   Registered, parametrised immediate-extension stage for the decode/execute boundary.
//   Extracts and sign-extends I/S/B/U/J immediates (optionally Z) to XLEN bits.
//   Carries a sideband tag and uses a valid/ready handshake.
//   A 2-entry skid buffer sustains 1 instr/cycle under backpressure.
//   Flags invalid selects and keeps a saturating error count.
// PARAMETERS
//   XLEN       32  output immediate width; legal values are 32 and 64
//   TAG_W      32  width of sideband tag (e.g. PC), passed through unchanged
//   ERR_CNT_W  8   width of the saturating invalid-select counter
// PORTS
//   clk_i        in   1        clock, rising edge
//   rst_i        in   1        reset, asynchronous, active-high
//   in_valid_i   in   1        input transfer valid
//   in_ready_o   out  1        stage can accept an input
//   imm_sel_i    in   3        I=0 S=1 B=2 U=3 J=4 Z=5 (shared defines); others invalid
//   instr_i      in   32       raw instruction word
//   tag_i        in   TAG_W    sideband tag
//   out_valid_o  out  1        output transfer valid
//   out_ready_i  in   1        downstream accepts output
//   imm_o        out  XLEN     extended immediate
//   tag_o        out  TAG_W    tag aligned with imm_o
//   err_o        out  1        imm_o came from an invalid select
//   err_cnt_o    out  ERR_CNT_W  count of accepted invalid selects, saturating
// BEHAVIOUR
//   - Transfers: in = in_valid_i & in_ready_o; out = out_valid_o & out_ready_i.
//   - Extraction (all sign-extended from instr_i[31] to XLEN):
//     - I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}
//     - U {31:12,12'b0}; J {31,19:12,20,30:21,0}
//     - invalid sel -> imm 0, err 1
//   - Computed combinationally at input; registered on acceptance. Latency 1 cycle.
//   - Buffer: main reg drives outputs; skid reg fills only when main is valid
//     and stalled during an input transfer.
//   - in_ready_o = ~skid_valid & ~rst_i.
//   - Out-transfer with skid valid: skid moves to main the same cycle.
//   - Simultaneous in+out with skid empty: main reloads; throughput 1/cycle.
//   - FIFO order is strict; nothing is dropped or duplicated.
//   - Full: 2 entries held -> in_ready_o = 0. Empty: out_valid_o = 0.
//   - Outputs (imm_o, tag_o, err_o) stay stable while out_valid_o & ~out_ready_i.
//   - err_cnt_o increments by 1 per accepted invalid select, counted at input
//     acceptance. It holds at all-ones and never wraps.
//   - Reset: async and immediate, including mid-operation.
//     - Outputs: out_valid_o=0, imm_o=0, tag_o=0, err_o=0, err_cnt_o=0; both
//       entries invalidated.
//     - in_ready_o=0 while rst_i=1, and 1 on the first cycle after release.
// CONFIGURATION
//   IMM_ZICSR_EN defined:
//     - sel 5 (Z) is valid
//     - imm = zero-extended instr_i[19:15] (CSR uimm), err=0
//   IMM_ZICSR_EN undefined:
//     - sel 5 is invalid: imm=0, err=1, counted
// TESTING
//   1. I-type: sel=0, instr=0xFFF00093 -> next cycle imm_o=0xFFFFFFFF
//      (XLEN=64: all ones), err_o=0.
//   2. B-type: sel=2, instr=0xFE000EE3, tag=0x100 -> imm_o=0xFFFFFFFC, tag_o=0x100.
//      U-type: sel=3, instr=0x800000B7 -> 0x80000000 (XLEN=64: 0xFFFFFFFF80000000).
//   3. Backpressure: out_ready_i=0, offer A,B,C back-to-back.
//      -> A,B accepted; in_ready_o=0 after B.
//      -> raise out_ready_i: outputs A then B, then C is accepted. Order kept.
//   4. Streaming: out_ready_i=1, 8 consecutive valid inputs -> 8 outputs on 8
//      consecutive cycles with 1-cycle latency.
//   5. Invalid/Z select:
//      - sel=7 -> imm_o=0, err_o=1, err_cnt_o+1.
//      - 300 invalid selects with ERR_CNT_W=8 -> err_cnt_o=0xFF.
//      - sel=5, instr[19:15]=0x1F -> 0x1F with IMM_ZICSR_EN; err_o=1 without.
//   6. Reset mid-op: 2 entries held, err_cnt=3, assert rst_i between clock edges.
//      -> out_valid_o=0, err_cnt_o=0 immediately.
//      -> after release, first accepted input emerges next cycle.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer and valid/ready handshake.
// Optional macro IMM_ZICSR_EN makes select 5 (CSR uimm, zero-extended) valid.
module imm_ext_pipe #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned TAG_W     = 32,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [2:0]           imm_sel_i,
   input  logic [31:0]          instr_i,
   input  logic [TAG_W-1:0]     tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [XLEN-1:0]      imm_o,
   output logic [TAG_W-1:0]     tag_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   typedef enum logic [2:0] {
      SEL_I = 3'd0,
      SEL_S = 3'd1,
      SEL_B = 3'd2,
      SEL_U = 3'd3,
      SEL_J = 3'd4,
      SEL_Z = 3'd5
   } imm_sel_e;

   imm_sel_e               sel;
   logic [31:0]            imm32;
   logic                   ext_err;
   logic [XLEN-1:0]        ext_imm;

   logic                   main_valid;
   logic [XLEN-1:0]        main_imm;
   logic [TAG_W-1:0]       main_tag;
   logic                   main_err;

   logic                   skid_valid;
   logic [XLEN-1:0]        skid_imm;
   logic [TAG_W-1:0]       skid_tag;
   logic                   skid_err;

   logic [ERR_CNT_W-1:0]   err_cnt;
   logic                   in_fire;
   logic                   out_fire;

   assign sel = imm_sel_e'(imm_sel_i);

   always_comb begin
      imm32   = '0;
      ext_err = 1'b0;
      case (sel)
         SEL_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         SEL_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         SEL_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         SEL_U:   imm32 = {instr_i[31:12], 12'b0};
         SEL_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
         SEL_Z:   imm32 = {27'b0, instr_i[19:15]};
`endif
         default: ext_err = 1'b1;
      endcase
   end

   // Widen from bit 31 of the 32-bit result; Z and invalid leave bit 31 clear.
   always_comb begin
      ext_imm       = {XLEN{imm32[31]}};
      ext_imm[31:0] = imm32;
   end

   assign in_ready_o = ~skid_valid & ~rst_i;
   assign in_fire    = in_valid_i & in_ready_o;
   assign out_fire   = main_valid & out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid <= 1'b0;
         main_imm   <= '0;
         main_tag   <= '0;
         main_err   <= 1'b0;
         skid_valid <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
         err_cnt    <= '0;
      end else begin
         // Main register frees up when drained or empty; the skid entry is older than any input.
         if (out_fire || !main_valid) begin
            if (skid_valid) begin
               main_valid <= 1'b1;
               main_imm   <= skid_imm;
               main_tag   <= skid_tag;
               main_err   <= skid_err;
               skid_valid <= 1'b0;
            end else if (in_fire) begin
               main_valid <= 1'b1;
               main_imm   <= ext_imm;
               main_tag   <= tag_i;
               main_err   <= ext_err;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_imm   <= ext_imm;
            skid_tag   <= tag_i;
            skid_err   <= ext_err;
         end

         if (in_fire && ext_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

   assign out_valid_o = main_valid;
   assign imm_o       = main_imm;
   assign tag_o       = main_tag;
   assign err_o       = main_err;
   assign err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (XLEN=32, TAG_W=32, ERR_CNT_W=8).
// Honours IMM_ZICSR_EN for the select-5 expectation.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  imm_sel;
   logic [31:0] instr;
   logic [31:0] tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm;
   logic [31:0] tag_out;
   logic        err;
   logic [7:0]  err_cnt;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned exp_cnt  = 0;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] instr;
      logic [31:0] tag;
      logic [31:0] imm;
      logic        err;
   } vec_t;

   vec_t vecs[12];

   imm_ext_pipe #(
      .XLEN      (32),
      .TAG_W     (32),
      .ERR_CNT_W (8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .imm_sel_i   (imm_sel),
      .instr_i     (instr),
      .tag_i       (tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .imm_o       (imm),
      .tag_o       (tag_out),
      .err_o       (err),
      .err_cnt_o   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] s, input logic [31:0] i, input logic [31:0] t);
      in_valid = 1'b1;
      imm_sel  = s;
      instr    = i;
      tag      = t;
   endtask

   task automatic bump_cnt();
      if (exp_cnt < 255) exp_cnt++;
   endtask

   initial begin
      vecs[0]  = '{3'd0, 32'hFFF00093, 32'h0000_0001, 32'hFFFFFFFF, 1'b0};
      vecs[1]  = '{3'd0, 32'h7FF00093, 32'h0000_0002, 32'h000007FF, 1'b0};
      vecs[2]  = '{3'd1, 32'h00A12223, 32'h0000_0003, 32'h00000004, 1'b0};
      vecs[3]  = '{3'd1, 32'hFE112E23, 32'h0000_0004, 32'hFFFFFFFC, 1'b0};
      vecs[4]  = '{3'd2, 32'hFE000EE3, 32'h0000_0100, 32'hFFFFFFFC, 1'b0};
      vecs[5]  = '{3'd3, 32'h800000B7, 32'h0000_0006, 32'h80000000, 1'b0};
      vecs[6]  = '{3'd3, 32'h12345037, 32'h0000_0007, 32'h12345000, 1'b0};
      vecs[7]  = '{3'd4, 32'h0080006F, 32'h0000_0008, 32'h00000008, 1'b0};
      vecs[8]  = '{3'd4, 32'hFFDFF06F, 32'h0000_0009, 32'hFFFFFFFC, 1'b0};
      vecs[9]  = '{3'd7, 32'hFFFFFFFF, 32'h0000_000A, 32'h00000000, 1'b1};
      vecs[10] = '{3'd6, 32'h800F8073, 32'h0000_000B, 32'h00000000, 1'b1};
`ifdef IMM_ZICSR_EN
      vecs[11] = '{3'd5, 32'h800F8073, 32'h0000_000C, 32'h0000001F, 1'b0};
`else
      vecs[11] = '{3'd5, 32'h800F8073, 32'h0000_000C, 32'h00000000, 1'b1};
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      imm_sel   = '0;
      instr     = '0;
      tag       = '0;
      tick();
      tick();
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_imm", {32'd0, imm}, 64'd0);
      chk("rst_tag", {32'd0, tag_out}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Single-transfer extraction table
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].sel, vecs[i].instr, vecs[i].tag);
         chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
         tick();
         in_valid = 1'b0;
         if (vecs[i].err) bump_cnt();
         chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("vec%0d_imm", i), {32'd0, imm}, {32'd0, vecs[i].imm});
         chk($sformatf("vec%0d_tag", i), {32'd0, tag_out}, {32'd0, vecs[i].tag});
         chk($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, vecs[i].err});
         chk($sformatf("vec%0d_err_cnt", i), {56'd0, err_cnt}, 64'(exp_cnt));
      end
      tick();
      chk("drain_empty", {63'd0, out_valid}, 64'd0);

      // Backpressure: A, B accepted; C waits; order kept
      out_ready = 1'b0;
      drive(3'd0, 32'h00A00013, 32'hA);
      tick();
      chk("bp_a_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_a_tag", {32'd0, tag_out}, 64'hA);
      chk("bp_ready_after_a", {63'd0, in_ready}, 64'd1);
      drive(3'd0, 32'h00B00013, 32'hB);
      tick();
      chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_a_tag", {32'd0, tag_out}, 64'hA);
      drive(3'd0, 32'h00C00013, 32'hC);
      tick();
      chk("bp_stable_imm", {32'd0, imm}, 64'hA);
      chk("bp_stable_tag", {32'd0, tag_out}, 64'hA);
      chk("bp_still_full", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_b_tag", {32'd0, tag_out}, 64'hB);
      chk("bp_b_imm", {32'd0, imm}, 64'hB);
      chk("bp_ready_again", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_c_tag", {32'd0, tag_out}, 64'hC);
      chk("bp_c_valid", {63'd0, out_valid}, 64'd1);
      tick();
      chk("bp_empty", {63'd0, out_valid}, 64'd0);

      // Streaming: one per cycle, 1-cycle latency
      for (int k = 0; k < 8; k++) begin
         drive(3'd0, {12'(k + 16), 20'h00013}, 32'(k + 32'h200));
         tick();
         chk($sformatf("stream%0d_valid", k), {63'd0, out_valid}, 64'd1);
         chk($sformatf("stream%0d_tag", k), {32'd0, tag_out}, 64'(k + 32'h200));
         chk($sformatf("stream%0d_imm", k), {32'd0, imm}, 64'(k + 16));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_empty", {63'd0, out_valid}, 64'd0);

      // Counter saturation
      for (int k = 0; k < 300; k++) begin
         drive(3'd7, 32'h12345678, 32'(k));
         tick();
         bump_cnt();
      end
      in_valid = 1'b0;
      chk("sat_err", {63'd0, err}, 64'd1);
      chk("sat_imm", {32'd0, imm}, 64'd0);
      chk("sat_model", {56'd0, err_cnt}, 64'(exp_cnt));
      chk("sat_ff", {56'd0, err_cnt}, 64'hFF);
      tick();

      // Reset mid-operation with two entries held and err_cnt=3
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      drive(3'd6, 32'h0, 32'h1);
      tick();
      drive(3'd6, 32'h0, 32'h2);
      tick();
      out_ready = 1'b0;
      drive(3'd7, 32'h0, 32'h3);
      tick();
      in_valid = 1'b0;
      chk("mid_full", {63'd0, in_ready}, 64'd0);
      chk("mid_cnt3", {56'd0, err_cnt}, 64'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_cnt", {56'd0, err_cnt}, 64'd0);
      chk("mid_rst_imm", {32'd0, imm}, 64'd0);
      chk("mid_rst_err", {63'd0, err}, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      drive(3'd0, 32'h12300013, 32'h55);
      tick();
      in_valid = 1'b0;
      chk("mid_first_valid", {63'd0, out_valid}, 64'd1);
      chk("mid_first_imm", {32'd0, imm}, 64'h123);
      chk("mid_first_tag", {32'd0, tag_out}, 64'h55);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
